multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: outputs are combinational from the state register and live inputs (Moore state, zero added latency).
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready=1. Build option MCTRL_ADDI_EN adds the addi path.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       redest,
    output logic       alusrca,
    output logic       illegal,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
`ifdef MCTRL_ADDI_EN
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`endif
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    // State register; reset lands in FETCH immediately, without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: instruction sequencing; any unused encoding falls back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op_code)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MCTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op_code == OP_SW) begin
                    state_d = MEMWR;
                end else if (op_code == OP_LW) begin
                    state_d = MEMRD;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
`ifdef MCTRL_ADDI_EN
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
`endif
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Outputs: per-state datapath controls; write enables are squashed while reset is held.
    always_comb begin
        pcwrite  = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        redest   = 1'b0;
        alusrca  = 1'b0;
        illegal  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        alu_ctrl = 3'b000;
        case (state_q)
            FETCH: begin
                irwrite  = mem_ready;
                pcwrite  = mem_ready;
                alusrcb  = 2'b01;
                alu_ctrl = ALU_ADD;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched.
                alusrcb  = 2'b11;
                alu_ctrl = ALU_ADD;
                case (op_code)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal = 1'b0;
`ifdef MCTRL_ADDI_EN
                    OP_ADDI: illegal = 1'b0;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_ctrl = ALU_ADD;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            ALUWB: begin
                regwrite = 1'b1;
                redest   = 1'b1;
            end
            BRANCH: begin
                alusrca  = 1'b1;
                alu_ctrl = ALU_SUB;
                pcsrc    = 2'b01;
                pcwrite  = zero;
            end
`ifdef MCTRL_ADDI_EN
            ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_ctrl = ALU_ADD;
            end
            ADDIWB: regwrite = 1'b1;
`endif
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction streams.
// Reference model walks a per-opcode list of states and derives expected controls per state.
// Outputs are sampled on the falling clock edge; inputs change 1ns after the rising edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_code;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, redest, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite),
        .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .redest(redest),
        .alusrca(alusrca), .illegal(illegal), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alu_ctrl(alu_ctrl), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] opc);
        if (opc == LW || opc == SW || opc == RT || opc == BEQ || opc == JMP) return 1'b1;
`ifdef MCTRL_ADDI_EN
        if (opc == ADDI) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Expected {pcwrite,irwrite,regwrite,memwrite,illegal, iord,memtoreg,redest,alusrca,alusrcb,pcsrc,alu_ctrl}
    function automatic logic [15:0] exp_out(input int st, input logic [5:0] opc, input logic [5:0] fn,
                                            input logic z, input logic mr);
        logic pw, iw, rw, mw, il, io, m2r, rd, a;
        logic [1:0] b, ps;
        logic [2:0] alu;
        {pw, iw, rw, mw, il, io, m2r, rd, a} = '0;
        b = 2'b00; ps = 2'b00; alu = 3'b000;
        case (st)
            0:  begin iw = mr; pw = mr; b = 2'b01; alu = 3'b010; end
            1:  begin b = 2'b11; alu = 3'b010; il = !is_legal(opc); end
            2:  begin a = 1'b1; b = 2'b10; alu = 3'b010; end
            3:  io = 1'b1;
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin
                    a = 1'b1;
                    alu = (fn == 6'b100010) ? 3'b110 : (fn == 6'b100100) ? 3'b000 :
                          (fn == 6'b100101) ? 3'b001 : (fn == 6'b101010) ? 3'b111 : 3'b010;
                end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin a = 1'b1; alu = 3'b110; ps = 2'b01; pw = z; end
            9:  begin a = 1'b1; b = 2'b10; alu = 3'b010; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        return {pw, iw, rw, mw, il, io, m2r, rd, a, b, ps, alu};
    endfunction

    // Model: the sequence of states an instruction visits, and position within it.
    int path[$];
    int idx;
    bit instr_done;
    int mw_seen;

    task automatic start_instr(input logic [5:0] opc);
        op_code = opc;
        case (opc)
            LW:   path = '{0, 1, 2, 3, 4};
            SW:   path = '{0, 1, 2, 5};
            RT:   path = '{0, 1, 6, 7};
            BEQ:  path = '{0, 1, 8};
            JMP:  path = '{0, 1, 11};
`ifdef MCTRL_ADDI_EN
            ADDI: path = '{0, 1, 9, 10};
`endif
            default: path = '{0, 1};
        endcase
        idx = 0;
        instr_done = 1'b0;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model on the rising edge.
    task automatic tick();
        logic [15:0] e, g;
        int st;
        @(negedge clk);
        st = path[idx];
        e = exp_out(st, op_code, funct, zero, mem_ready);
        g = {pcwrite, irwrite, regwrite, memwrite, illegal, iord, memtoreg, redest, alusrca,
             alusrcb, pcsrc, alu_ctrl};
        chk("state", 32'(state), 32'(st));
        chk("enables", 32'(g[15:11]), 32'(e[15:11]));
        chk("controls", 32'(g[10:0]), 32'(e[10:0]));
        if (memwrite) mw_seen++;
        @(posedge clk);
        if (!((st == 0 || st == 3 || st == 5) && !mem_ready)) idx++;
        if (idx >= path.size()) instr_done = 1'b1;
        #1;
    endtask

    task automatic count_cycles(input string tag, input logic [5:0] opc, input int exp_n);
        int n;
        start_instr(opc);
        mem_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (state != 4'd0 && n < 20);
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 6))
            0: return LW;
            1: return SW;
            2: return RT;
            3: return BEQ;
            4: return ADDI;
            5: return JMP;
            default: begin
                o = 6'($urandom);
                while (o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP) o = 6'($urandom);
                return o;
            end
        endcase
    endfunction

    function automatic logic [5:0] rand_funct();
        case ($urandom_range(0, 5))
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            4: return 6'b101010;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        int cnt;
        rst_n = 1'b0; op_code = LW; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        mw_seen = 0;
        // Reset held across clock edges: FETCH with write enables squashed despite mem_ready=1.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enables", 32'({pcwrite, irwrite, regwrite, memwrite, illegal}), 32'd0);
        rst_n = 1'b1;

        // Cycle counts with mem_ready held high (lw sequence also checks per-state controls).
        count_cycles("cyc_lw", LW, 5);
        count_cycles("cyc_sw", SW, 4);
        funct = 6'b100010;
        count_cycles("cyc_rtype_sub", RT, 4);
        zero = 1'b1;
        count_cycles("cyc_beq_taken", BEQ, 3);
        zero = 1'b0;
        count_cycles("cyc_beq_nottaken", BEQ, 3);
        count_cycles("cyc_j", JMP, 3);
`ifdef MCTRL_ADDI_EN
        count_cycles("cyc_addi", ADDI, 4);
`else
        count_cycles("cyc_addi_illegal", ADDI, 2);
`endif
        count_cycles("cyc_illegal", 6'b111111, 2);

        // Store stalled three cycles in MEMWR: memwrite for four cycles, then FETCH.
        start_instr(SW);
        mem_ready = 1'b1;
        repeat (3) tick();
        mw_seen = 0;
        mem_ready = 1'b0;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        chk("sw_stall_memwrite_cycles", 32'(mw_seen), 32'd4);
        chk("sw_stall_back_to_fetch", 32'(state), 32'd0);

        // Asynchronous reset in MEMRD: state returns to FETCH before any clock edge.
        start_instr(LW);
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("pre_async_in_memrd", 32'(state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_enables", 32'({pcwrite, irwrite, regwrite, memwrite, illegal}), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(state), 32'd0);
        rst_n = 1'b1;

        // Randomized instruction stream with random memory stalls, zero flag and funct.
        for (int i = 0; i < 300; i++) begin
            start_instr(rand_op());
            cnt = 0;
            while (!instr_done && cnt < 200) begin
                mem_ready = ($urandom_range(0, 9) < 7);
                zero = 1'($urandom);
                funct = rand_funct();
                tick();
                cnt++;
            end
            if (!instr_done) chk("rand_instr_timeout", 32'(cnt), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
